// File: rtl/uart_pkg.sv
// =============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART constants, transmit-arbiter state encoding and helpers.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package uart_pkg;

   localparam int UART_DATA_W       = 8;
   localparam int DEF_N_REQ         = 4;
   localparam int DEF_START_TIMEOUT = 16;
   localparam int DEF_GAP_CYCLES    = 2;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_LAUNCH     = 3'd1,
      ST_WAIT_START = 3'd2,
      ST_WAIT_DONE  = 3'd3,
      ST_GAP        = 3'd4
   } arb_state_e;

   // Index/counter width that never collapses to zero bits.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// =============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin pick, searching upward from last_i+1.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module rr_pick
   import uart_pkg::*;
#(
   parameter  int N_REQ = DEF_N_REQ,
   localparam int IDW   = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDW-1:0]   last_i,
   output logic [IDW-1:0]   winner_o,
   output logic             any_valid_o
);

   always_comb begin
      int             idx;
      logic [IDW-1:0] sel;
      idx         = 0;
      sel         = '0;
      winner_o    = '0;
      any_valid_o = 1'b0;
      // First set bit after last_i wins; last_i itself is visited last.
      for (int k = 1; k <= N_REQ; k++) begin
         idx = int'(last_i) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         sel = IDW'(idx);
         if (req_i[sel] && !any_valid_o) begin
            any_valid_o = 1'b1;
            winner_o    = sel;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/u_tx_arb.sv
// =============================================================================
//  Module   : u_tx_arb
//  Purpose  : Round-robin arbiter feeding bytes from N_REQ requesters to one u_tx.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module u_tx_arb
   import uart_pkg::*;
#(
   parameter  int N_REQ         = DEF_N_REQ,
   parameter  int START_TIMEOUT = DEF_START_TIMEOUT,
   parameter  int GAP_CYCLES    = DEF_GAP_CYCLES,
   localparam int IDW           = idx_w(N_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [8*N_REQ-1:0]       req_data,
   output logic [N_REQ-1:0]         req_ready,
   output logic                     tx_send,
   output logic [UART_DATA_W-1:0]   tx_data,
   input  logic                     tx_active,
   output logic [IDW-1:0]           grant_id,
   output logic                     busy,
   output logic                     err_timeout
);

   localparam int CNT_W = idx_w(START_TIMEOUT);
   localparam int GAP_W = idx_w(GAP_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam arb_state_e       POST_ST  = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

   arb_state_e             state_q, state_d;
   logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
   logic [IDW-1:0]         grant_q, grant_d;
   logic [IDW-1:0]         last_q, last_d;
   logic [CNT_W-1:0]       start_cnt_q, start_cnt_d;
   logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
   logic                   tx_send_q, tx_send_d;
   logic                   err_q, err_d;

   logic [IDW-1:0]         w_winner;
   logic                   w_any;
   logic [N_REQ-1:0]       w_ready;
   logic [UART_DATA_W-1:0] w_byte;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .req_i       (req_valid),
      .last_i      (last_q),
      .winner_o    (w_winner),
      .any_valid_o (w_any)
   );

   always_comb begin
      w_byte = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_winner == IDW'(i)) begin
            w_byte = req_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      tx_data_d   = tx_data_q;
      grant_d     = grant_q;
      last_d      = last_q;
      start_cnt_d = start_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      tx_send_d   = 1'b0;
      err_d       = 1'b0;
      w_ready     = '0;
      case (state_q)
         ST_IDLE: begin
            // A still-busy u_tx holds off the next grant.
            if (w_any && !tx_active) begin
               w_ready[w_winner] = 1'b1;
               tx_data_d         = w_byte;
               grant_d           = w_winner;
               last_d            = w_winner;
               tx_send_d         = 1'b1;
               state_d           = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            start_cnt_d = '0;
            state_d     = ST_WAIT_START;
         end
         ST_WAIT_START: begin
            if (tx_active) begin
               state_d = ST_WAIT_DONE;
            end else if (start_cnt_q == CNT_LAST) begin
               err_d     = 1'b1;
               gap_cnt_d = '0;
               state_d   = POST_ST;
            end else begin
               start_cnt_d = start_cnt_q + CNT_W'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_active) begin
               gap_cnt_d = '0;
               state_d   = POST_ST;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         tx_data_q   <= '0;
         grant_q     <= '0;
         last_q      <= IDW'(N_REQ - 1);
         start_cnt_q <= '0;
         gap_cnt_q   <= '0;
         tx_send_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_data_q   <= tx_data_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         start_cnt_q <= start_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         tx_send_q   <= tx_send_d;
         err_q       <= err_d;
      end
   end

   // The accept pulse must not escape while reset discards the grant.
   assign req_ready   = rst ? '0 : w_ready;
   assign tx_send     = tx_send_q;
   assign tx_data     = tx_data_q;
   assign grant_id    = grant_q;
   assign busy        = (state_q != ST_IDLE);
   assign err_timeout = err_q;

endmodule

`default_nettype wire

// File: doc/u_tx_arb.md
U_TX_ARB -- requirements
Module: u_tx_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of byte requesters sharing one u_tx.
REQ-002 SHALL have parameter START_TIMEOUT, default 16, max clk cycles waited for tx_active after a tx_send pulse.
REQ-003 SHALL have parameter GAP_CYCLES, default 2, idle clk cycles inserted after each frame before the next grant.
REQ-004 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-005 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: req_valid  in  N_REQ  requester i holds a byte for transmission.
REQ-007 SHALL have ports: req_data  in  8*N_REQ  byte of requester i at bits [8i+7:8i].
REQ-008 SHALL have ports: req_ready  out  N_REQ  one-cycle accept pulse, at most one bit set.
REQ-009 SHALL have ports: tx_send  out  1  one-cycle start pulse to u_tx.
REQ-010 SHALL have ports: tx_data  out  8  byte presented to u_tx data_in.
REQ-011 SHALL have ports: tx_active  in  1  u_tx busy indication.
REQ-012 SHALL have ports: grant_id  out  clog2(N_REQ)  index of requester owning current/last frame.
REQ-013 SHALL have ports: busy  out  1  high in every state except IDLE.
REQ-014 SHALL have ports: err_timeout  out  1  one-cycle pulse when tx_active never rose.

Function
REQ-015 SHALL implement FSM states IDLE, LAUNCH, WAIT_START, WAIT_DONE, GAP.
REQ-016 IDLE with any req_valid set SHALL select the winner round-robin, searching upward from last_grant+1 with wrap at N_REQ-1 to 0.
REQ-017 In the selecting IDLE cycle SHALL assert req_ready[winner], register req_data of winner into tx_data, set grant_id and last_grant to winner, go to LAUNCH.
REQ-018 IDLE with req_valid all zero SHALL stay in IDLE with req_ready zero.
REQ-019 LAUNCH SHALL assert tx_send for exactly one cycle, clear the start counter, go to WAIT_START.
REQ-020 tx_data SHALL remain stable from LAUNCH until the next grant.
REQ-021 WAIT_START with tx_active=1 SHALL go to WAIT_DONE.
REQ-022 WAIT_START with tx_active=0 SHALL increment the start counter; when it reaches START_TIMEOUT-1, SHALL pulse err_timeout and go to GAP; the byte is dropped, not retried.
REQ-023 WAIT_DONE SHALL stay while tx_active=1 and go to GAP on the first cycle tx_active=0.
REQ-024 GAP SHALL last exactly GAP_CYCLES cycles, then go to IDLE; GAP_CYCLES=0 SHALL go from WAIT_DONE/WAIT_START directly to IDLE.
REQ-025 Request-to-tx_send latency SHALL be exactly 1 cycle (ready in cycle n, tx_send in cycle n+1).
REQ-026 req_valid changes outside IDLE SHALL be ignored; requesters hold valid/data until their req_ready.
REQ-027 A requester deasserting valid before grant SHALL simply lose eligibility; no state kept.
REQ-028 With a single requester continuously valid, SHALL grant it every frame.
REQ-029 tx_active high while in IDLE SHALL block new grants until it falls.

Reset
REQ-030 rst=1 SHALL force, on the next clk edge: state IDLE, tx_send 0, tx_data 0, req_ready 0, grant_id 0, busy 0, err_timeout 0, counters 0, last_grant N_REQ-1 (requester 0 first priority).
REQ-031 rst asserted mid-frame SHALL abort the frame without tx_send re-pulse; rst takes priority over all transitions.

Structure
REQ-032 State encoding and default widths SHALL live in shared package uart_pkg alongside other UART constants.
REQ-033 Round-robin winner selection SHALL be sub-module rr_pick (combinational, inputs req mask and last_grant, outputs winner and any_valid).
REQ-034 u_tx SHALL NOT be instantiated inside; connection is at the parent level.

Verification
REQ-035 Single request: req_valid=0001, req_data[7:0]=8'hAA -> req_ready=0001 one cycle, tx_send next cycle, tx_data=8'hAA, grant_id=0.
REQ-036 Fairness: req_valid=1111 held, data 8'h10/8'h21/8'h32/8'h43 -> grants order 0,1,2,3,0 with u_tx model holding tx_active 10 cycles.
REQ-037 Timeout: u_tx model never raises tx_active -> err_timeout pulse 16 cycles after WAIT_START entry, then GAP 2 cycles, IDLE, next requester served.
REQ-038 Gap: with GAP_CYCLES=2, tx_active fall to next req_ready exactly 3 cycles when a request is pending.
REQ-039 Reset mid-frame: rst=1 during WAIT_DONE -> all outputs at reset values next edge; after release req_valid=1000 grants 3 with no residual tx_send.
REQ-040 Real u_tx in loop, 100 MHz clk, baud tick every 8680 ns: bytes 8'hAA then 8'hF0 from two requesters appear serialized in order on tx_data_out with no overlap.
